// File: rtl/imm_pkg.sv
// imm_pkg: opcodes, immediate-type tags, buffer state and entry layout shared by imm_gen_pipe
package imm_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_Z,
        IMM_C
    } imm_type_e;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_e;

    // Fields are sized for the widest datapath; narrower builds use the low XLEN bits.
    typedef struct packed {
        logic [MAX_XLEN-1:0] imm;
        imm_type_e           itype;
        logic [MAX_XLEN-1:0] target;
        logic [MAX_XLEN-1:0] pc;
    } entry_t;

    localparam entry_t ENTRY_RST = '{imm: '0, itype: IMM_NONE, target: '0, pc: '0};

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational opcode-to-immediate/type decode; IMM_GEN_RVC_EN adds compressed (IMM_C) decode
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       itype
);

    logic [6:0]  op;
    logic [31:0] imm32;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, z_imm;

    assign op    = instr[6:0];
    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};
    assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign z_imm = {27'b0, instr[19:15]};

    // Every 32-bit value here is either sign-extended or has bit 31 clear, so one sign extension serves all.
    assign imm = XLEN'($signed(imm32));

    // Select the immediate format from the major opcode; unknown encodings yield a zero immediate.
    always_comb begin
        itype = IMM_NONE;
        imm32 = '0;
        if (op == OP_IMM || op == OP_LOAD || op == OP_JALR) begin
            itype = IMM_I;
            imm32 = i_imm;
        end else if (op == OP_STORE) begin
            itype = IMM_S;
            imm32 = s_imm;
        end else if (op == OP_BRANCH) begin
            itype = IMM_B;
            imm32 = b_imm;
        end else if (op == OP_LUI || op == OP_AUIPC) begin
            itype = IMM_U;
            imm32 = u_imm;
        end else if (op == OP_JAL) begin
            itype = IMM_J;
            imm32 = j_imm;
        end else if (op == OP_SYSTEM && instr[14]) begin
            itype = IMM_Z;
            imm32 = z_imm;
        end
`ifdef IMM_GEN_RVC_EN
        if (instr[1:0] == 2'b01 && (instr[15:13] == 3'b000 || instr[15:13] == 3'b010)) begin
            itype = IMM_C;
            imm32 = {{26{instr[12]}}, instr[12], instr[6:2]};
        end else if (instr[1:0] == 2'b00 && (instr[15:13] == 3'b010 || instr[15:13] == 3'b110)) begin
            itype = IMM_C;
            imm32 = {25'b0, instr[5], instr[12:10], instr[6], 2'b00};
        end else if (instr[1:0] == 2'b01 && (instr[15:13] == 3'b101 || instr[15:13] == 3'b001)) begin
            itype = IMM_C;
            imm32 = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                     instr[2], instr[11], instr[5:3], 1'b0};
        end else if (instr[1:0] == 2'b01 && instr[15:14] == 2'b11) begin
            itype = IMM_C;
            imm32 = {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};
        end
`endif
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate + PC-relative target generation behind a two-entry skid buffer; IMM_GEN_RVC_EN enables compressed decode
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc
);

    imm_type_e       dec_type;
    logic [XLEN-1:0] dec_imm, dec_target;
    entry_t          in_e, main_q, skid_q;
    state_e          state, state_nx;
    logic            acc, drn;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr (in_instr),
        .imm   (dec_imm),
        .itype (dec_type)
    );

    assign dec_target = in_pc + dec_imm;
    assign in_e = '{imm: MAX_XLEN'(dec_imm), itype: dec_type,
                    target: MAX_XLEN'(dec_target), pc: MAX_XLEN'(in_pc)};

    assign out_valid  = state != EMPTY;
    assign in_ready   = state != FULL;
    assign acc        = in_valid && in_ready;
    assign drn        = out_valid && out_ready;
    assign out_imm    = main_q.imm[XLEN-1:0];
    assign out_type   = main_q.itype;
    assign out_target = main_q.target[XLEN-1:0];
    assign out_pc     = main_q.pc[XLEN-1:0];

    if (XLEN < MAX_XLEN) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{main_q.imm[MAX_XLEN-1:XLEN], main_q.target[MAX_XLEN-1:XLEN],
                             main_q.pc[MAX_XLEN-1:XLEN]};
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    // Occupancy transitions; flush overrides any concurrent accept or drain.
    always_comb begin
        state_nx = state;
        if (flush)                state_nx = EMPTY;
        else if (state == EMPTY)  state_nx = acc ? ONE : EMPTY;
        else if (state == ONE)    state_nx = (acc && !drn) ? FULL : (drn && !acc) ? EMPTY : ONE;
        else                      state_nx = drn ? ONE : FULL;
    end

    // Main is the head of the FIFO; skid only holds the second entry while main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= ENTRY_RST;
            skid_q <= ENTRY_RST;
        end else if (!flush) begin
            if (state == FULL) begin
                if (drn) main_q <= skid_q;
            end else if (acc && (state == EMPTY || drn)) begin
                main_q <= in_e;
            end else if (acc) begin
                skid_q <= in_e;
            end
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate-generation stage for the micore RV32I/RV64I front end. Each accepted instruction yields its sign-extended immediate, an immediate-type tag and a precomputed PC-relative target. A valid/ready skid buffer sits between fetch and decode/execute. Unlike a purely combinational generator, it adds XLEN generalisation, CSR zimm decoding, target precomputation, flush and backpressure.

## Interface
- XLEN, 32: datapath width, 32 or 64; immediates sign-extend to XLEN.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  generated immediate.
- out_type  out  3  imm_type_e tag.
- out_target  out  XLEN  in_pc + out_imm, modulo 2^XLEN.
- out_pc  out  XLEN  pass-through PC.

## Operation
- Opcode decode, instr[6:0]:
  - 0010011 / 0000011 / 1100111 → IMM_I: sext(instr[31:20]).
  - 0100011 → IMM_S: sext({[31:25],[11:7]}).
  - 1100011 → IMM_B: sext({[31],[7],[30:25],[11:8],0}).
  - 0110111 / 0010111 → IMM_U: sext({[31:12],12'b0}). This is an upper-bit sign-extension when XLEN=64.
  - 1101111 → IMM_J: sext({[31],[19:12],[20],[30:21],0}).
  - 1110011 with funct3[2]=1 → IMM_Z: zero-extend instr[19:15].
  - Anything else → IMM_NONE: imm 0, target = pc.
- out_target is always pc + imm and is computed in the same stage.
- Storage is a two-entry skid buffer, main plus skid, and strictly FIFO.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions:
  - accept only → count+1.
  - drain only → count−1.
  - accept and drain in ONE → stays ONE, and the new data replaces main.
- flush forces EMPTY on the next edge. When flush coincides with an accept or drain, flush wins and the input is discarded.

## Timing
- Latency: 1 cycle from the in_valid&&in_ready edge to out_valid.
- Throughput: 1 instruction/cycle while out_ready=1.
- in_ready deasserts the cycle after entering FULL and reasserts the cycle after the skid drains.
- Output fields are stable while out_valid=1 and out_ready=0.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_target=0, out_pc=0, out_type=IMM_NONE.
- Reset asserted mid-operation empties the buffer immediately, asynchronously.

## Configuration
- IMM_GEN_RVC_EN defined: when in_instr[1:0]≠11, the 16-bit low half is decoded as compressed, tag IMM_C:
  - C.ADDI / C.LI: sext({[12],[6:2]}).
  - C.LW: zext({[5],[12:10],[6],00}).
  - C.SW: same formula as C.LW.
  - C.J / C.JAL: sext 12-bit jump offset.
  - C.BEQZ / C.BNEZ: sext 9-bit branch offset.
  - out_target uses these offsets.
- IMM_GEN_RVC_EN undefined: in_instr[1:0] is ignored, decoding is 32-bit only, and IMM_C never appears.

## Structure
- Package imm_pkg holds:
  - opcode localparams.
  - imm_type_e (IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_C).
  - a packed struct {imm, type, target, pc} used for buffer entries.
- Sub-module imm_decode holds the combinational opcode-to-immediate/type logic, parametrised by XLEN. imm_gen_pipe instantiates it and owns the skid buffer and adder.

## Test plan
- addi x1,x0,-1 (0xFFF00093), pc 0x0 → one cycle later out_imm=0xFFFFFFFF, type IMM_I, target 0xFFFFFFFF.
- beq x0,x0,-4 (0xFE000EE3), pc 0x100 → out_imm=0xFFFFFFFC, IMM_B, target 0x0FC. With XLEN=64 → out_imm=0xFFFFFFFFFFFFFFFC.
- lui x5,0x12345 (0x123452B7) → imm 0x12345000, IMM_U. jal x1,+2048 (0x001000EF), pc 0x1000 → imm 0x800, target 0x1800.
- csrrwi x0,mstatus,5 (0x3002D073) → imm 5, IMM_Z. csrrw (funct3=001) → imm 0, IMM_NONE.
- Continuous input with out_ready=0 for 3 cycles:
  - in_ready falls after the second accept.
  - Release drains both entries in order, with no loss or duplication.
- flush asserted together with in_valid while FULL → the next cycle has out_valid=0 and in_ready=1, and the flushed instruction never appears.
